// File: rtl/multiply_arbiter.sv
// rtl/multiply_arbiter.sv - round-robin arbiter sharing one pipelined multiply among N requesters
// Issues one operand pair per cycle and routes each returning product back to its requester.
module multiply_arbiter #(
  parameter int N        = 4,
  parameter int WDTH     = 16,
  parameter int MULT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  input  logic [N*WDTH-1:0]   in_x,
  input  logic [N*WDTH-1:0]   in_y,
  output logic [N-1:0]        out_valid,
  output logic [WDTH-1:0]     out_z,
  output logic                busy,
  output logic [WDTH-1:0]     mult_x,
  output logic [WDTH-1:0]     mult_y,
  input  logic [WDTH-1:0]     mult_z
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  // Stage 0 lines up with mult_x/mult_y, the last stage with mult_z.
  localparam int STG  = MULT_LAT + 1;

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_next;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] cand;
  logic            grant_any;
  logic [N-1:0]    grant;
  logic [STG-1:0]  tag_valid;
  logic [IDXW-1:0] tag_idx [STG];
  logic [N-1:0]    last_onehot;
  int              j;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    grant     = '0;
    cand      = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      cand = IDXW'(j);
      if (in_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    if (grant_any && rst_n) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign in_ready = grant;
  assign ptr_next = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    last_onehot = '0;
    last_onehot[tag_idx[STG-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      mult_x    <= '0;
      mult_y    <= '0;
      tag_valid <= '0;
      for (int s = 0; s < STG; s++) begin
        tag_idx[s] <= '0;
      end
      out_valid <= '0;
      out_z     <= '0;
    end else begin
      if (grant_any) begin
        ptr    <= ptr_next;
        mult_x <= in_x[grant_idx*WDTH +: WDTH];
        mult_y <= in_y[grant_idx*WDTH +: WDTH];
      end
      tag_valid[0] <= grant_any;
      tag_idx[0]   <= grant_idx;
      for (int s = 1; s < STG; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      if (tag_valid[STG-1]) begin
        out_valid <= last_onehot;
        out_z     <= mult_z;
      end else begin
        out_valid <= '0;
      end
    end
  end

  assign busy = |tag_valid;

endmodule
